// File: rtl/pcpu_pkg.sv
// Shared pcpu definitions: default address width, vectors, and the PC action
// encoding with the priority decode used by the fetch-stage sequencer.
package pcpu_pkg;

    localparam int PCPU_AW = 16;
    localparam int PCPU_RAS_DEPTH = 4;
    localparam logic [PCPU_AW-1:0] PCPU_RESET_VEC = 16'h0000;
    localparam logic [PCPU_AW-1:0] PCPU_IRQ_VEC = 16'h0001;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_CALL,
        PC_RET,
        PC_IRET,
        PC_IRQ
    } pc_action_e;

    // Exactly one action per cycle; a taken interrupt pre-empts the
    // instruction in flight, which is re-fetched after iret.
    function automatic pc_action_e pc_decode(
        input logic stall,
        input logic take,
        input logic inc,
        input logic load,
        input logic call,
        input logic ret,
        input logic iret
    );
        pc_action_e act;
        act = PC_HOLD;
        if (!stall && (inc || load || call || ret || iret)) begin
            if (take) begin
                act = PC_IRQ;
            end else if (iret) begin
                act = PC_IRET;
            end else if (ret) begin
                act = PC_RET;
            end else if (call) begin
                act = PC_CALL;
            end else if (load) begin
                act = PC_LOAD;
            end else begin
                act = PC_INC;
            end
        end
        return act;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with saturating occupancy count and sticky
// overflow/underflow flags; pushing while full silently replaces the oldest entry.
module pc_ras
    import pcpu_pkg::*;
#(
    parameter int AW    = PCPU_AW,
    parameter int DEPTH = PCPU_RAS_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] push_data_i,
    output logic [AW-1:0] top_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          ovf_o,
    output logic          unf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] top_ptr;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          do_push;

    // wr_ptr always names the next free slot; when full that slot holds the
    // oldest entry, so a push there is the circular overwrite.
    assign top_ptr = wr_ptr_q - PTR_ONE;
    assign top_o   = mem_q[top_ptr];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;
    assign do_push = push_i && !pop_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (pop_i) begin
            if (empty_o) begin
                unf_d = 1'b1;
            end else begin
                wr_ptr_d = top_ptr;
                count_d  = count_q - CNT_ONE;
            end
        end else if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (full_o) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Entry storage needs no reset: count=0 makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage program-counter sequencer: jump/call/return via a hardware RAS,
// a latched maskable interrupt with saved EPC and iret, and stall.
module pc_seq
    import pcpu_pkg::*;
#(
    parameter int          AW        = PCPU_AW,
    parameter int          RAS_DEPTH = PCPU_RAS_DEPTH,
    parameter logic [AW-1:0] RESET_VEC = AW'(PCPU_RESET_VEC),
    parameter logic [AW-1:0] IRQ_VEC   = AW'(PCPU_IRQ_VEC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          inc,
    input  logic          load,
    input  logic          call,
    input  logic          ret,
    input  logic          iret,
    input  logic [AW-1:0] target,
    input  logic          irq,
    input  logic          irq_en,
    output logic [AW-1:0] pc,
    output logic          irq_taken,
    output logic          in_irq,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_ovf,
    output logic          ras_unf
);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] epc_q, epc_d;
    logic          pending_q, pending_d;
    logic          in_irq_q, in_irq_d;
    logic          irq_taken_q;
    logic          take;
    logic          ras_push, ras_pop;
    logic [AW-1:0] ras_top;
    logic [AW-1:0] pc_plus1;
    pc_action_e    action;

    assign pc_plus1 = pc_q + AW'(1);
    assign take     = pending_q && irq_en && !in_irq_q;
    assign action   = pc_decode(stall, take, inc, load, call, ret, iret);

    pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_plus1),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full),
        .ovf_o       (ras_ovf),
        .unf_o       (ras_unf)
    );

    always_comb begin
        pc_d      = pc_q;
        epc_d     = epc_q;
        in_irq_d  = in_irq_q;
        pending_d = pending_q | irq;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        case (action)
            PC_IRQ: begin
                epc_d     = pc_q;
                pc_d      = IRQ_VEC;
                in_irq_d  = 1'b1;
                pending_d = 1'b0;
            end
            PC_IRET: begin
                if (in_irq_q) begin
                    pc_d     = epc_q;
                    in_irq_d = 1'b0;
                end else begin
                    pc_d = pc_plus1;
                end
            end
            PC_RET: begin
                ras_pop = 1'b1;
                pc_d    = ras_empty ? pc_plus1 : ras_top;
            end
            PC_CALL: begin
                ras_push = 1'b1;
                pc_d     = target;
            end
            PC_LOAD: pc_d = target + AW'(inc);
            PC_INC:  pc_d = pc_plus1;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_VEC;
            epc_q       <= '0;
            pending_q   <= 1'b0;
            in_irq_q    <= 1'b0;
            irq_taken_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            pending_q   <= pending_d;
            in_irq_q    <= in_irq_d;
            irq_taken_q <= (action == PC_IRQ);
        end
    end

    assign pc        = pc_q;
    assign in_irq    = in_irq_q;
    assign irq_taken = irq_taken_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: a reference model predicts pc/flags per driven cycle into a
// queue, compared after each clock edge, plus directed checks against constants.
module tb_pc_seq;

    localparam int AW = 16;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] IRQ_V = 16'h0001;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0, inc = 1'b0, load = 1'b0, call = 1'b0;
    logic          ret = 1'b0, iret = 1'b0, irq = 1'b0, irq_en = 1'b0;
    logic [AW-1:0] target = '0;
    logic [AW-1:0] pc;
    logic          irq_taken, in_irq, ras_empty, ras_full, ras_ovf, ras_unf;

    pc_seq dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .inc       (inc),
        .load      (load),
        .call      (call),
        .ret       (ret),
        .iret      (iret),
        .target    (target),
        .irq       (irq),
        .irq_en    (irq_en),
        .pc        (pc),
        .irq_taken (irq_taken),
        .in_irq    (in_irq),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    // clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    // Expected entry: {pc, irq_taken, in_irq, empty, full, ovf, unf}
    logic [AW+5:0] exp_q[$];

    logic [AW-1:0] m_pc, m_epc;
    logic          m_pend, m_in_irq, m_taken, m_ovf, m_unf;
    logic [AW-1:0] m_stack[$];

    function automatic logic [5:0] dut_flags();
        return {irq_taken, in_irq, ras_empty, ras_full, ras_ovf, ras_unf};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        m_epc = '0;
        m_pend = 1'b0;
        m_in_irq = 1'b0;
        m_taken = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_step();
        logic take;
        logic step_any;
        step_any = inc | load | call | ret | iret;
        take = m_pend && irq_en && !m_in_irq && !stall && step_any;
        m_taken = take;
        if (!stall && step_any) begin
            if (take) begin
                m_epc = m_pc;
                m_pc = IRQ_V;
                m_in_irq = 1'b1;
            end else if (iret) begin
                if (m_in_irq) begin
                    m_pc = m_epc;
                    m_in_irq = 1'b0;
                end else begin
                    m_pc = m_pc + 16'd1;
                end
            end else if (ret) begin
                if (m_stack.size() == 0) begin
                    m_pc = m_pc + 16'd1;
                    m_unf = 1'b1;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end else if (call) begin
                m_stack.push_back(m_pc + 16'd1);
                if (m_stack.size() > DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1'b1;
                end
                m_pc = target;
            end else if (load) begin
                m_pc = target + {15'd0, inc};
            end else begin
                m_pc = m_pc + 16'd1;
            end
        end
        m_pend = take ? 1'b0 : (m_pend | irq);
    endtask

    // driver: apply one cycle of inputs at negedge, predict, then compare
    task automatic drive(input logic s, input logic i, input logic l, input logic c,
                         input logic r, input logic ir, input logic [AW-1:0] t,
                         input logic q);
        logic [AW+5:0] e;
        stall = s; inc = i; load = l; call = c; ret = r; iret = ir; target = t; irq = q;
        model_step();
        exp_q.push_back({m_pc, m_taken, m_in_irq, (m_stack.size() == 0),
                         (m_stack.size() == DEPTH), m_ovf, m_unf});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("pc", {16'd0, pc}, {16'd0, e[AW+5:6]});
            check("flags", {26'd0, dut_flags()}, {26'd0, e[5:0]});
        end
    endtask

    task automatic do_reset();
        stall = 0; inc = 0; load = 0; call = 0; ret = 0; iret = 0; irq = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_pc", {16'd0, pc}, 32'h0);
        check("rst_flags", {26'd0, dut_flags()}, 32'b001000);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // run a little, then reset mid-run
        drive(0, 1, 0, 0, 0, 0, 16'h0, 0);
        drive(0, 0, 1, 0, 0, 0, 16'h0333, 0);
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 0, 0, 0, 0, 16'h0, 0);
            check("inc_seq", {16'd0, pc}, k);
        end

        drive(0, 1, 1, 0, 0, 0, 16'h0100, 0);
        check("load_inc", {16'd0, pc}, 32'h0101);
        drive(0, 0, 1, 0, 0, 0, 16'hFFFF, 0);
        drive(0, 1, 0, 0, 0, 0, 16'h0, 0);
        check("pc_wrap", {16'd0, pc}, 32'h0000);

        // nested call/ret
        drive(0, 0, 1, 0, 0, 0, 16'h0010, 0);
        drive(0, 0, 0, 1, 0, 0, 16'h0080, 0);
        check("call1", {16'd0, pc}, 32'h0080);
        drive(0, 0, 0, 1, 0, 0, 16'h0090, 0);
        check("call2", {16'd0, pc}, 32'h0090);
        drive(0, 0, 0, 0, 1, 0, 16'h0, 0);
        check("ret1", {16'd0, pc}, 32'h0081);
        drive(0, 0, 0, 0, 1, 0, 16'h0, 0);
        check("ret2", {16'd0, pc}, 32'h0011);
        check("ret_empty", {31'd0, ras_empty}, 32'd1);

        // overflow then underflow
        drive(0, 0, 1, 0, 0, 0, 16'h0100, 0);
        for (int k = 2; k <= 6; k++) begin
            drive(0, 0, 0, 1, 0, 0, 16'(k * 16'h0100), 0);
        end
        check("ovf", {31'd0, ras_ovf}, 32'd1);
        check("ovf_full", {31'd0, ras_full}, 32'd1);
        for (int k = 5; k >= 2; k--) begin
            drive(0, 0, 0, 0, 1, 0, 16'h0, 0);
            check("ovf_ret", {16'd0, pc}, 32'(k * 256 + 1));
        end
        drive(0, 0, 0, 0, 1, 0, 16'h0, 0);
        check("unf_pc", {16'd0, pc}, 32'h0202);
        check("unf", {31'd0, ras_unf}, 32'd1);

        // irq latched during stall
        do_reset();
        irq_en = 1'b1;
        drive(0, 0, 1, 0, 0, 0, 16'h0020, 0);
        drive(1, 1, 0, 0, 0, 0, 16'h0, 1);
        check("stall_hold", {16'd0, pc}, 32'h0020);
        drive(0, 1, 0, 0, 0, 0, 16'h0, 0);
        check("irq_vec", {16'd0, pc}, {16'd0, IRQ_V});
        check("irq_pulse", {30'd0, irq_taken, in_irq}, 32'b11);
        drive(0, 0, 0, 0, 0, 1, 16'h0, 0);
        check("iret_pc", {16'd0, pc}, 32'h0020);
        check("iret_flags", {30'd0, irq_taken, in_irq}, 32'b00);

        // masked irq stays pending until enabled
        irq_en = 1'b0;
        drive(0, 1, 0, 0, 0, 0, 16'h0, 1);
        drive(0, 1, 0, 0, 0, 0, 16'h0, 0);
        check("masked", {16'd0, pc}, 32'h0022);
        irq_en = 1'b1;
        drive(0, 1, 0, 0, 0, 0, 16'h0, 0);
        check("unmask_take", {16'd0, pc}, {16'd0, IRQ_V});

        // irq inside handler: iret first, then vector again
        drive(0, 1, 0, 0, 0, 0, 16'h0, 1);
        check("no_nest", {16'd0, pc}, 32'h0002);
        drive(0, 0, 0, 0, 0, 1, 16'h0, 0);
        check("iret_epc", {16'd0, pc}, 32'h0022);
        drive(0, 1, 0, 0, 0, 0, 16'h0, 0);
        check("second_take", {16'd0, pc}, {16'd0, IRQ_V});

        // call+ret together: ret wins, no push
        do_reset();
        drive(0, 0, 1, 0, 0, 0, 16'h0040, 0);
        drive(0, 0, 0, 1, 0, 0, 16'h0050, 0);
        drive(0, 0, 0, 1, 1, 0, 16'h0070, 0);
        check("callret_pc", {16'd0, pc}, 32'h0041);
        check("callret_empty", {31'd0, ras_empty}, 32'd1);

        // reset mid-stall inside handler
        drive(0, 1, 0, 0, 0, 0, 16'h0, 1);
        drive(1, 1, 0, 0, 0, 0, 16'h0, 1);
        do_reset();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            irq_en = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0),
                  16'($urandom_range(0, 16'hFFFF)),
                  ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
